// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard/forwarding controller.
package hazard_pkg;

  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef enum logic {
    RUN    = 1'b0,
    LSTALL = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand EX forwarding select; a load in MEM is only forwarded once it reaches WB.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned FWD_EN = 1
) (
  input  logic [REG_AW-1:0] i_src,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic              i_mem_regwrite,
  input  logic              i_mem_is_load,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic              i_wb_regwrite,
  output logic [1:0]        o_sel
);

  logic w_hit_mem;
  logic w_hit_wb;

  assign w_hit_mem = i_mem_regwrite && !i_mem_is_load && (i_mem_rd != '0) && (i_mem_rd == i_src);
  assign w_hit_wb  = i_wb_regwrite && (i_wb_rd != '0) && (i_wb_rd == i_src);

  always_comb begin
    o_sel = FWD_RF;
    if (FWD_EN != 0) begin
      if (w_hit_mem)     o_sel = FWD_EXMEM;
      else if (w_hit_wb) o_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / RAW stall, memory freeze, branch flush and forwarding control
// for the five-stage pipeline, with saturating bubble/flush counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned OPC_W    = 7,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned FWD_EN   = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              clear,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [OPC_W-1:0]  ex_op,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic              mem_is_load,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  input  logic              branch_taken,
  input  logic              dmem_busy,
  output logic              pc_hold,
  output logic              ifid_hold,
  output logic              ifid_flush,
  output logic              idex_wk,
  output logic              pipe_freeze,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [2:0] LAT_M1     = 3'(LOAD_LAT - 1);
  localparam bit         USE_LSTALL = (FWD_EN != 0) && (LOAD_LAT > 1);

  hz_state_t        r_state;
  logic [2:0]       r_scnt;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic       w_raw_ex;
  logic       w_raw_mem;
  logic       w_hz_ld;
  logic       w_hz;
  logic       w_stall;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  assign w_raw_ex  = ex_regwrite && (ex_rd != '0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  assign w_raw_mem = mem_regwrite && (mem_rd != '0) &&
                     ((id_use_rs1 && (id_rs1 == mem_rd)) || (id_use_rs2 && (id_rs2 == mem_rd)));
  assign w_hz_ld   = (ex_op == OPC_W'(OPC_LOAD)) && w_raw_ex;
  // Without forwarding every in-flight writer must drain before ID may read.
  assign w_hz      = (FWD_EN != 0) ? w_hz_ld : (w_raw_ex || w_raw_mem);
  assign w_stall   = (r_state == LSTALL) || w_hz;

  hazard_fwd_sel #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_a (
    .i_src          (ex_rs1),
    .i_mem_rd       (mem_rd),
    .i_mem_regwrite (mem_regwrite),
    .i_mem_is_load  (mem_is_load),
    .i_wb_rd        (wb_rd),
    .i_wb_regwrite  (wb_regwrite),
    .o_sel          (w_fwd_a)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_b (
    .i_src          (ex_rs2),
    .i_mem_rd       (mem_rd),
    .i_mem_regwrite (mem_regwrite),
    .i_mem_is_load  (mem_is_load),
    .i_wb_rd        (wb_rd),
    .i_wb_regwrite  (wb_regwrite),
    .o_sel          (w_fwd_b)
  );

  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    pipe_freeze = 1'b0;
    idex_wk     = 1'b1;
    if (clear) begin
      idex_wk = 1'b0;
    end else if (dmem_busy) begin
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      pipe_freeze = 1'b1;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
      idex_wk    = 1'b0;
    end else if (w_stall) begin
      pc_hold   = 1'b1;
      ifid_hold = 1'b1;
      idex_wk   = 1'b0;
    end
  end

  assign fwd_a      = clear ? FWD_RF : w_fwd_a;
  assign fwd_b      = clear ? FWD_RF : w_fwd_b;
  assign bubble_cnt = r_bubble_cnt;
  assign flush_cnt  = r_flush_cnt;

  always_ff @(posedge CLK) begin
    if (clear) begin
      r_state      <= RUN;
      r_scnt       <= '0;
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else if (!dmem_busy) begin
      if (branch_taken) begin
        r_state <= RUN;
        r_scnt  <= '0;
        if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end else if (r_state == LSTALL) begin
        if (r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        if (r_scnt <= 3'd1) begin
          r_state <= RUN;
          r_scnt  <= '0;
        end else begin
          r_scnt <= r_scnt - 3'd1;
        end
      end else if (w_hz) begin
        if (r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        if (USE_LSTALL) begin
          r_state <= LSTALL;
          r_scnt  <= LAT_M1;
        end
      end
    end
  end

endmodule
